// File: rtl/ravenoc_pkg.sv
// Shared NoC types: flit request/response, head-flit layout, port directions
// and the XY routing / output-index helpers used by the router input port.
package ravenoc_pkg;

    localparam int NumVirtChn = 2;
    localparam int VcWidth    = $clog2(NumVirtChn);
    localparam int FlitWidth  = 32;
    localparam int XWidth     = 4;
    localparam int YWidth     = 4;
    localparam int PktSzWidth = 8;

    // Bit positions of the head-flit fields inside a raw flit word.
    localparam int TypeLsb      = FlitWidth - 2;
    localparam int XLsb         = TypeLsb - XWidth;
    localparam int YLsb         = XLsb - YWidth;
    localparam int SzLsb        = YLsb - PktSzWidth;
    localparam int PayloadWidth = SzLsb;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_t;

    typedef enum logic [2:0] {
        LOCAL_PORT = 3'd0,
        NORTH_PORT = 3'd1,
        SOUTH_PORT = 3'd2,
        WEST_PORT  = 3'd3,
        EAST_PORT  = 3'd4
    } s_port_dir_t;

    typedef enum logic {
        ZeroHighPrior = 1'b0,
        ZeroLowPrior  = 1'b1
    } s_prior_t;

    // ZeroLowPrior: the highest VC index wins arbitration.
    localparam s_prior_t HighPriority = ZeroLowPrior;

    typedef struct packed {
        logic                 valid;
        logic [VcWidth-1:0]   vc_id;
        logic [FlitWidth-1:0] fdata;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

    typedef struct packed {
        flit_type_t              type_f;
        logic [XWidth-1:0]       x_dest;
        logic [YWidth-1:0]       y_dest;
        logic [PktSzWidth-1:0]   pkt_size;
        logic [PayloadWidth-1:0] payload;
    } s_flit_head_data_t;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic s_port_dir_t xy_route(input logic [XWidth-1:0] x_dest,
                                             input logic [YWidth-1:0] y_dest,
                                             input logic [XWidth-1:0] x_here,
                                             input logic [YWidth-1:0] y_here);
        s_port_dir_t dir;
        if (x_dest > x_here)      dir = EAST_PORT;
        else if (x_dest < x_here) dir = WEST_PORT;
        else if (y_dest > y_here) dir = SOUTH_PORT;
        else if (y_dest < y_here) dir = NORTH_PORT;
        else                      dir = LOCAL_PORT;
        return dir;
    endfunction

    // Output vector excludes this port's own direction, so directions above it shift down by one.
    function automatic logic [1:0] dir_to_idx(input s_port_dir_t dir, input s_port_dir_t own);
        logic [2:0] raw;
        raw = (dir > own) ? (3'(dir) - 3'd1) : 3'(dir);
        return raw[1:0];
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-clock flit FIFO for one virtual channel; extra pointer bit separates full from empty.
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             read,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_ff;
    logic [AW:0]      rd_ptr_ff;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr_ff == rd_ptr_ff);
    assign full  = (wr_ptr_ff[AW] != rd_ptr_ff[AW]) && (wr_ptr_ff[AW-1:0] == rd_ptr_ff[AW-1:0]);
    assign rdata = mem[rd_ptr_ff[AW-1:0]];

    // Pointer control; a push and a pop may happen in the same cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_ff <= '0;
            rd_ptr_ff <= '0;
        end else begin
            if (write && !full) wr_ptr_ff <= wr_ptr_ff + 1'b1;
            if (read && !empty) rd_ptr_ff <= rd_ptr_ff + 1'b1;
        end
    end

    // Storage array carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (write && !full) mem[wr_ptr_ff[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/router_input_port.sv
// Router ingress port: per-VC buffering, XY route tracking per packet,
// discard of malformed/U-turn flits and a single locked request toward the outputs.
module router_input_port
    import ravenoc_pkg::*;
#(
    parameter int          ROUTER_X_ID = 0,
    parameter int          ROUTER_Y_ID = 0,
    parameter s_port_dir_t PORT_DIR    = LOCAL_PORT,
    parameter int          BUFF_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               arst,
    input  s_flit_req_t        fin_req_i,
    output s_flit_resp_t       fin_resp_o,
    output s_flit_req_t  [3:0] fout_req_o,
    input  s_flit_resp_t [3:0] fout_resp_i,
    output logic               err_o
);

    localparam logic [XWidth-1:0] RouterX = XWidth'(ROUTER_X_ID);
    localparam logic [YWidth-1:0] RouterY = YWidth'(ROUTER_Y_ID);

    logic [NumVirtChn-1:0]                full, empty, write, pop;
    logic [NumVirtChn-1:0][FlitWidth-1:0] top;
    logic [NumVirtChn-1:0]                route_vld_ff;
    s_port_dir_t                          route_ff   [NumVirtChn];
    s_port_dir_t                          head_route [NumVirtChn];
    s_port_dir_t                          cur_route  [NumVirtChn];
    logic [NumVirtChn-1:0]                is_head, is_tail, single, discard, cand;
    logic                                 sel_lock_ff, sel_vld, hs;
    logic [VcWidth-1:0]                   sel_vc_ff, sel_vc, dsc_vc;
    logic [1:0]                           sel_idx;

    assign fin_resp_o.ready = ~full[fin_req_i.vc_id];

    for (genvar v = 0; v < NumVirtChn; v++) begin : g_vc
        assign write[v] = fin_req_i.valid && fin_resp_o.ready && (fin_req_i.vc_id == VcWidth'(v));

        vc_fifo #(
            .DEPTH (BUFF_DEPTH),
            .WIDTH (FlitWidth)
        ) u_fifo (
            .clk   (clk),
            .arst  (arst),
            .write (write[v]),
            .wdata (fin_req_i.fdata),
            .read  (pop[v]),
            .rdata (top[v]),
            .full  (full[v]),
            .empty (empty[v])
        );
    end

    // Decode each FIFO top: flit type, route of a head, and whether it must be dropped.
    always_comb begin
        for (int v = 0; v < NumVirtChn; v++) begin
            is_head[v]    = (top[v][TypeLsb +: 2] == HEAD_FLIT);
            is_tail[v]    = (top[v][TypeLsb +: 2] == TAIL_FLIT);
            single[v]     = (top[v][SzLsb +: PktSzWidth] == '0);
            head_route[v] = xy_route(top[v][XLsb +: XWidth], top[v][YLsb +: YWidth], RouterX, RouterY);
            cur_route[v]  = route_vld_ff[v] ? route_ff[v] : head_route[v];
            discard[v]    = !empty[v] && (route_vld_ff[v] ? is_head[v]
                                                          : (!is_head[v] || head_route[v] == PORT_DIR));
            cand[v]       = !empty[v] && !discard[v];
        end
    end

    // Pick the VC to present; a stalled presentation keeps its VC until accepted.
    always_comb begin
        sel_vc  = sel_vc_ff;
        sel_vld = sel_lock_ff;
        if (!sel_lock_ff) begin
            sel_vld = |cand;
            sel_vc  = '0;
            if (HighPriority == ZeroLowPrior) begin
                for (int v = 0; v < NumVirtChn; v++)
                    if (cand[v]) sel_vc = v[VcWidth-1:0];
            end else begin
                for (int v = NumVirtChn - 1; v >= 0; v--)
                    if (cand[v]) sel_vc = v[VcWidth-1:0];
            end
        end
        sel_idx = dir_to_idx(cur_route[sel_vc], PORT_DIR);
    end

    // Drive the single active request, and pop on handshake or on a discard.
    always_comb begin
        fout_req_o = '0;
        pop        = '0;
        hs         = 1'b0;
        dsc_vc     = '0;
        if (sel_vld) begin
            fout_req_o[sel_idx].valid = 1'b1;
            fout_req_o[sel_idx].vc_id = sel_vc;
            fout_req_o[sel_idx].fdata = top[sel_vc];
            hs                        = fout_resp_i[sel_idx].ready;
            pop[sel_vc]               = hs;
        end
        for (int v = NumVirtChn - 1; v >= 0; v--)
            if (discard[v]) dsc_vc = v[VcWidth-1:0];
        if (|discard) pop[dsc_vc] = 1'b1;
    end

    // Control state: per-VC packet tracking, presentation lock and discard pulse.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            route_vld_ff <= '0;
            sel_lock_ff  <= 1'b0;
            sel_vc_ff    <= '0;
            err_o        <= 1'b0;
        end else begin
            err_o       <= |discard;
            sel_lock_ff <= sel_vld && !hs;
            if (sel_vld) sel_vc_ff <= sel_vc;
            if (hs) begin
                if (!route_vld_ff[sel_vc])     route_vld_ff[sel_vc] <= !single[sel_vc];
                else if (is_tail[sel_vc])      route_vld_ff[sel_vc] <= 1'b0;
            end
        end
    end

    // Latched packet route; only meaningful while route_vld_ff is set.
    always_ff @(posedge clk) begin
        if (hs && !route_vld_ff[sel_vc]) route_ff[sel_vc] <= head_route[sel_vc];
    end

endmodule

// File: tb/tb_router_input_port.sv
// Scoreboard bench for router_input_port at router (1,1) serving the WEST input.
`timescale 1ns/1ps
module tb_router_input_port;
    import ravenoc_pkg::*;

    localparam int          RX       = 1;
    localparam int          RY       = 1;
    localparam int          PORT_NUM = 3;
    localparam s_port_dir_t PORT     = WEST_PORT;

    typedef struct packed {
        logic [1:0]  k;
        logic [31:0] d;
    } exp_t;

    logic               clk = 1'b0;
    logic               arst = 1'b1;
    s_flit_req_t        fin_req;
    s_flit_resp_t       fin_resp;
    s_flit_req_t  [3:0] fout_req;
    s_flit_resp_t [3:0] fout_resp;
    logic               err;
    logic [3:0]         rdy;

    int   checks = 0;
    int   failures = 0;
    int   err_seen = 0;
    int   exp_discards = 0;
    int   pl = 1;
    exp_t q0[$];
    exp_t q1[$];
    int   m_in_pkt[2];
    int   m_route[2];
    logic        stall_pending = 1'b0;
    int          stall_k;
    s_flit_req_t stall_f;

    router_input_port #(
        .ROUTER_X_ID (RX),
        .ROUTER_Y_ID (RY),
        .PORT_DIR    (PORT),
        .BUFF_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .fin_req_i   (fin_req),
        .fin_resp_o  (fin_resp),
        .fout_req_o  (fout_req),
        .fout_resp_i (fout_resp),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 4; k++) fout_resp[k].ready = rdy[k];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, req, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int t, input int x, input int y, input int sz, input int p);
        s_flit_head_data_t h;
        h.type_f   = flit_type_t'(t[1:0]);
        h.x_dest   = x[3:0];
        h.y_dest   = y[3:0];
        h.pkt_size = sz[7:0];
        h.payload  = p[13:0];
        return h;
    endfunction

    // Reference direction numbering: LOCAL 0, NORTH 1, SOUTH 2, WEST 3, EAST 4.
    function automatic int xy_dir(input int x, input int y);
        if (x > RX) return 4;
        if (x < RX) return 3;
        if (y > RY) return 2;
        if (y < RY) return 1;
        return 0;
    endfunction

    // Position of a direction in the list of the other four, ascending.
    function automatic int out_idx(input int dir);
        int k = 0;
        for (int d = 0; d < 5; d++) begin
            if (d != PORT_NUM) begin
                if (d == dir) return k;
                k++;
            end
        end
        return -1;
    endfunction

    task automatic expect_out(input int vc, input int dir, input logic [31:0] d);
        exp_t e;
        e.k = 2'(out_idx(dir));
        e.d = d;
        if (vc == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Packet-level semantics of one VC: every accepted flit is either forwarded or discarded.
    task automatic model_push(input int vc, input logic [31:0] d);
        s_flit_head_data_t h;
        int t, dir;
        h = d;
        t = int'(h.type_f);
        if (m_in_pkt[vc] == 0) begin
            if (t != 0) exp_discards++;
            else begin
                dir = xy_dir(int'(h.x_dest), int'(h.y_dest));
                if (dir == PORT_NUM) exp_discards++;
                else begin
                    expect_out(vc, dir, d);
                    if (h.pkt_size != 0) begin
                        m_in_pkt[vc] = 1;
                        m_route[vc]  = dir;
                    end
                end
            end
        end else begin
            if (t == 0) exp_discards++;
            else begin
                expect_out(vc, m_route[vc], d);
                if (t == 2) m_in_pkt[vc] = 0;
            end
        end
    endtask

    // Monitor: records accepted flits into the model and checks every presented flit.
    always @(negedge clk) begin
        int   nval, kk;
        exp_t e;
        logic have;
        if (arst) begin
            q0.delete();
            q1.delete();
            m_in_pkt[0]   = 0;
            m_in_pkt[1]   = 0;
            stall_pending = 1'b0;
            exp_discards  = err_seen;
        end else begin
            if (err) err_seen++;
            if (fin_req.valid && fin_resp.ready) model_push(int'(fin_req.vc_id), fin_req.fdata);
            nval = 0;
            kk   = 0;
            for (int k = 0; k < 4; k++) begin
                if (fout_req[k].valid) begin
                    nval++;
                    kk = k;
                end
            end
            if (nval > 1) check("one_valid", 64'(nval), 64'd1);
            if (nval == 1) begin
                if (stall_pending) begin
                    check("hold_idx", 64'(kk), 64'(stall_k));
                    check("hold_flit", 64'(fout_req[kk]), 64'(stall_f));
                end
                if (rdy[kk]) begin
                    stall_pending = 1'b0;
                    have = 1'b0;
                    if (fout_req[kk].vc_id == 1'b0) begin
                        if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    end else begin
                        if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    end
                    check("egress_expected", 64'(have), 64'd1);
                    if (have) begin
                        check("egress_idx", 64'(kk), 64'(e.k));
                        check("egress_data", 64'(fout_req[kk].fdata), 64'(e.d));
                    end
                end else begin
                    stall_pending = 1'b1;
                    stall_k       = kk;
                    stall_f       = fout_req[kk];
                end
            end else if (stall_pending) begin
                check("hold_dropped", 64'd0, 64'd1);
                stall_pending = 1'b0;
            end
        end
    end

    task automatic send(input int vc, input int t, input int x, input int y, input int sz);
        int n = 0;
        fin_req.valid = 1'b1;
        fin_req.vc_id = vc[0];
        fin_req.fdata = mk(t, x, y, sz, pl);
        pl++;
        @(negedge clk);
        while (!fin_resp.ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("ingress_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1 fin_req.valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rdy = 4'hF;
        while ((q0.size() + q1.size()) != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("drain", 64'(q0.size() + q1.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int nvalid();
        int n = 0;
        for (int k = 0; k < 4; k++) if (fout_req[k].valid) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e0;
        logic done;
        fin_req = '0;
        rdy     = 4'h0;
        m_in_pkt[0] = 0;
        m_in_pkt[1] = 0;
        #12;
        check("rst_fout_valid", 64'(nvalid()), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ready", 64'(fin_resp.ready), 64'd1);
        @(posedge clk);
        #3 arst = 1'b0;
        @(posedge clk);
        #1;

        // Single-flit head eastbound, visible the cycle after acceptance.
        rdy = 4'hF;
        send(0, 0, 2, 1, 0);
        @(negedge clk);
        check("t1_east_valid", 64'(fout_req[3].valid), 64'd1);
        check("t1_vc", 64'(fout_req[3].vc_id), 64'd0);
        drain();

        // Three-flit northbound packet with toggling ready.
        rdy = 4'h0;
        fork
            begin
                send(1, 0, 1, 0, 2);
                send(1, 1, 0, 0, 0);
                send(1, 2, 0, 0, 0);
            end
            begin
                repeat (12) begin
                    @(posedge clk);
                    #1 rdy[1] = ~rdy[1];
                end
            end
        join
        drain();
        send(1, 0, 1, 0, 0);
        @(negedge clk);
        check("t2_route_cleared", 64'(fout_req[1].valid), 64'd1);
        drain();

        // Fill vc0 while stalled.
        rdy = 4'h0;
        send(0, 0, 2, 1, 3);
        send(0, 1, 0, 0, 0);
        send(0, 1, 0, 0, 0);
        send(0, 2, 0, 0, 0);
        fin_req.vc_id = 1'b0;
        #1 check("t3_full_vc0", 64'(fin_resp.ready), 64'd0);
        fin_req.vc_id = 1'b1;
        #1 check("t3_ready_vc1", 64'(fin_resp.ready), 64'd1);
        @(posedge clk);
        #1 drain();

        // Lock: stalled vc0 holds off a higher-priority vc1.
        rdy = 4'h0;
        send(0, 0, 2, 1, 0);
        send(1, 0, 1, 2, 0);
        repeat (3) begin
            @(negedge clk);
            check("t4_hold_vc0", 64'({fout_req[3].valid, fout_req[3].vc_id}), 64'b10);
            check("t4_no_vc1", 64'(fout_req[2].valid), 64'd0);
        end
        @(posedge clk);
        #1 rdy = 4'hF;
        @(negedge clk);
        check("t4_vc0_first", 64'({fout_req[3].valid, fout_req[3].vc_id}), 64'b10);
        @(negedge clk);
        check("t4_vc1_next", 64'({fout_req[2].valid, fout_req[2].vc_id}), 64'b11);
        drain();

        // U-turn head and orphan body both dropped.
        rdy = 4'hF;
        e0  = err_seen;
        send(0, 0, 0, 1, 1);
        send(0, 1, 0, 0, 0);
        repeat (6) @(negedge clk);
        check("t5_err_pulses", 64'(err_seen - e0), 64'd2);
        @(posedge clk);
        #1;
        // Head inside an open packet is dropped, the route survives.
        rdy = 4'h0;
        send(0, 0, 1, 0, 2);
        send(0, 0, 2, 1, 0);
        rdy = 4'hF;
        send(0, 2, 0, 0, 0);
        drain();
        check("t5_err_total", 64'(err_seen), 64'(exp_discards));

        // Reset mid-packet.
        rdy = 4'h0;
        send(1, 0, 1, 2, 3);
        send(1, 1, 0, 0, 0);
        @(posedge clk);
        #3 arst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(nvalid()), 64'd0);
        check("t6_rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #3 arst = 1'b0;
        @(posedge clk);
        #1 rdy = 4'hF;
        send(1, 0, 1, 0, 0);
        @(negedge clk);
        check("t6_north_after_rst", 64'({fout_req[1].valid, fout_req[1].vc_id}), 64'b11);
        drain();

        // Random flit mix on both VCs against random output readiness.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int r, t;
                    r = int'($urandom_range(0, 3));
                    t = (r <= 1) ? 0 : r - 1;
                    send(int'($urandom_range(0, 1)), t, int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 rdy = 4'($urandom);
                end
            end
        join
        drain();
        repeat (4) @(negedge clk);
        check("final_err_count", 64'(err_seen), 64'(exp_discards));
        check("final_queues_empty", 64'(q0.size() + q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
